// File: rtl/imem_responder.sv
// Instruction memory responder: serves registered 32-bit fetches with alignment/range
// checking, and accepts a little-endian byte-stream program load into the same RAM.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IMEM_addr_i,
    input  logic        IMEM_read_n_i,
    output logic [31:0] IMEM_data_o,
    output logic        IMEM_err_o,
    input  logic        load_start_i,
    input  logic [31:0] load_base_i,
    input  logic [7:0]  load_byte_i,
    input  logic        load_valid_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        busy_o,
    output logic        load_done_o
);
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FINISH} state_t;

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        load_ready_q, load_ready_d;
    logic        busy_q, busy_d;
    logic        load_done_q, load_done_d;
    logic [31:0] data_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Fetch address decode; the 33-bit compare keeps 4*DEPTH_WORDS from overflowing.
    logic [31:0]      rd_offset;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;

    assign rd_offset = IMEM_addr_i - BASE_ADDR;
    assign rd_ok     = (IMEM_addr_i >= BASE_ADDR) && ({1'b0, rd_offset} < MEM_BYTES)
                       && (rd_offset[1:0] == 2'b00);
    assign rd_idx    = rd_offset[IDX_W+1:2];

    // Assembly register with the incoming byte merged into lane cnt.
    logic [31:0] lane_word;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_word[8*gi +: 8] = (cnt_q == 2'(gi)) ? load_byte_i : asm_q[8*gi +: 8];
    end

    logic accept;
    logic mem_we;

    assign accept = (state_q == ST_LOAD) && load_valid_i;
    assign mem_we = !reset && accept && ((cnt_q == 2'd3) || load_last_i) && (ptr_q < DEPTH_LIM);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = (load_base_i - BASE_ADDR) >> 2;
                    cnt_d   = 2'd0;
                    asm_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    asm_d = lane_word;
                    // Clear after a full word so a short final word has zero upper lanes.
                    if (cnt_q == 2'd3) begin
                        asm_d = '0;
                        ptr_d = ptr_q + 32'd1;
                    end
                    if (load_last_i) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        load_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE);
        load_done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= 2'd0;
            asm_q        <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[IDX_W-1:0]] <= lane_word;
        end
    end

    // Registered read port; memory is only read while idle, so no write collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= NOP_WORD;
            err_q  <= 1'b0;
        end else if (!IMEM_read_n_i) begin
            if (state_q != ST_IDLE) begin
                data_q <= NOP_WORD;
                err_q  <= 1'b0;
            end else if (rd_ok) begin
                data_q <= mem[rd_idx];
                err_q  <= 1'b0;
            end else begin
                data_q <= NOP_WORD;
                err_q  <= 1'b1;
            end
        end
    end

    assign IMEM_data_o  = data_q;
    assign IMEM_err_o   = err_q;
    assign load_ready_o = load_ready_q;
    assign busy_o       = busy_q;
    assign load_done_o  = load_done_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder: loads images, fetches them back and checks
// handshake flags, hold behaviour, error flags, overflow discard and reset abort.
module tb_imem_responder;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IMEM_addr_i = '0;
    logic        IMEM_read_n_i = 1'b1;
    logic [31:0] IMEM_data_o;
    logic        IMEM_err_o;
    logic        load_start_i = 1'b0;
    logic [31:0] load_base_i = '0;
    logic [7:0]  load_byte_i = '0;
    logic        load_valid_i = 1'b0;
    logic        load_last_i = 1'b0;
    logic        load_ready_o;
    logic        busy_o;
    logic        load_done_o;

    imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .IMEM_addr_i(IMEM_addr_i), .IMEM_read_n_i(IMEM_read_n_i),
        .IMEM_data_o(IMEM_data_o), .IMEM_err_o(IMEM_err_o),
        .load_start_i(load_start_i), .load_base_i(load_base_i),
        .load_byte_i(load_byte_i), .load_valid_i(load_valid_i), .load_last_i(load_last_i),
        .load_ready_o(load_ready_o), .busy_o(busy_o), .load_done_o(load_done_o)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [DEPTH];
    logic        model_busy = 1'b0;
    logic [31:0] held_data = NOP;
    logic        held_err = 1'b0;
    logic [31:0] sb_data [$];
    logic        sb_err [$];
    logic [7:0]  ld_bytes [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge: predict the output register for this edge, then compare after it.
    task automatic tick();
        logic [31:0] ed;
        logic [31:0] off;
        logic        ee;
        off = IMEM_addr_i - BASE;
        ed  = held_data;
        ee  = held_err;
        if (reset) begin
            ed = NOP; ee = 1'b0;
        end else if (!IMEM_read_n_i) begin
            if (model_busy) begin
                ed = NOP; ee = 1'b0;
            end else if (IMEM_addr_i >= BASE && off < 4 * DEPTH && off[1:0] == 2'b00) begin
                ed = model_mem[off >> 2]; ee = 1'b0;
            end else begin
                ed = NOP; ee = 1'b1;
            end
        end
        held_data = ed;
        held_err  = ee;
        sb_data.push_back(ed);
        sb_err.push_back(ee);
        @(negedge clk);
        chk("data_o", IMEM_data_o, sb_data.pop_front());
        chk("err_o", 32'(IMEM_err_o), 32'(sb_err.pop_front()));
    endtask

    task automatic do_read(input logic [31:0] addr);
        IMEM_read_n_i = 1'b0;
        IMEM_addr_i   = addr;
        tick();
        IMEM_read_n_i = 1'b1;
        $display("read  addr=%h data=%h err=%b", addr, IMEM_data_o, IMEM_err_o);
    endtask

    task automatic do_load(input logic [31:0] base, input int unsigned gap_max,
                           input logic read_during);
        int          n;
        int unsigned gaps;
        logic [31:0] w;
        logic [31:0] idx;
        n = ld_bytes.size();
        load_start_i = 1'b1;
        load_base_i  = base;
        tick();
        load_start_i = 1'b0;
        model_busy   = 1'b1;
        chk("busy_start", 32'(busy_o), 32'd1);
        chk("ready_start", 32'(load_ready_o), 32'd1);
        if (read_during) begin
            IMEM_read_n_i = 1'b0;
            IMEM_addr_i   = base;
        end
        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < int'(gaps); g++) begin
                // Idle cycles: stray last and a competing start must both be ignored.
                load_valid_i = 1'b0;
                load_last_i  = 1'($urandom_range(1, 0));
                load_start_i = 1'b1;
                load_base_i  = BASE + 32'h20;
                tick();
                chk("busy_gap", 32'(busy_o), 32'd1);
                chk("done_gap", 32'(load_done_o), 32'd0);
            end
            load_start_i = 1'b0;
            load_valid_i = 1'b1;
            load_byte_i  = ld_bytes[i];
            load_last_i  = (i == n - 1);
            tick();
        end
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
        chk("done_pulse", 32'(load_done_o), 32'd1);
        chk("busy_finish", 32'(busy_o), 32'd1);
        chk("ready_finish", 32'(load_ready_o), 32'd0);
        tick();
        model_busy    = 1'b0;
        IMEM_read_n_i = 1'b1;
        chk("done_clear", 32'(load_done_o), 32'd0);
        chk("busy_clear", 32'(busy_o), 32'd0);
        chk("ready_clear", 32'(load_ready_o), 32'd0);
        for (int i = 0; i < n; i += 4) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
                if (i + l < n) w[8*l +: 8] = ld_bytes[i + l];
            end
            idx = ((base - BASE) >> 2) + 32'(i / 4);
            if (idx < DEPTH) model_mem[idx] = w;
        end
        $display("load  base=%h bytes=%0d gap_max=%0d", base, n, gap_max);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(load_ready_o), 32'd0);
        chk("rst_done", 32'(load_done_o), 32'd0);
        $display("reset released");

        ld_bytes = '{8'h13, 8'h05, 8'h10, 8'h00};
        do_load(BASE, 0, 1'b0);
        do_read(BASE);
        chk("mem0_word", IMEM_data_o, 32'h0010_0513);
        IMEM_read_n_i = 1'b1;
        IMEM_addr_i   = BASE + 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_data", IMEM_data_o, 32'h0010_0513);
        end
        $display("hold  3 cycles data=%h", IMEM_data_o);

        do_read(BASE + 32'h2);
        chk("misalign_err", 32'(IMEM_err_o), 32'd1);
        do_read(BASE + 4 * DEPTH);
        chk("oor_err", 32'(IMEM_err_o), 32'd1);
        do_read(BASE - 32'd4);
        chk("below_err", 32'(IMEM_err_o), 32'd1);

        ld_bytes = '{8'hAA, 8'hBB, 8'hCC};
        do_load(BASE + 32'd8, 0, 1'b0);
        do_read(BASE + 32'd8);
        chk("partial_word", IMEM_data_o, 32'h00CC_BBAA);

        do_read(BASE + 32'h3);
        ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_load(BASE + 32'd16, 3, 1'b1);
        do_read(BASE + 32'd16);
        chk("gap_word0", IMEM_data_o, 32'h4433_2211);
        do_read(BASE + 32'd20);
        chk("gap_word1", IMEM_data_o, 32'h0000_6655);

        ld_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(BASE + 4 * (DEPTH - 1), 2, 1'b1);
        do_read(BASE + 4 * (DEPTH - 1));
        chk("last_word", IMEM_data_o, 32'h0403_0201);
        do_read(BASE);
        chk("no_wrap", IMEM_data_o, 32'h0010_0513);

        // Abort a load after two bytes; nothing may reach memory and no done pulse.
        load_start_i = 1'b1;
        load_base_i  = BASE;
        tick();
        load_start_i = 1'b0;
        model_busy   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_valid_i = 1'b1;
            load_byte_i  = 8'hE0 + 8'(i);
            tick();
        end
        load_valid_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_busy = 1'b0;
        chk("abort_data", IMEM_data_o, NOP);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready", 32'(load_ready_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("abort_done", 32'(load_done_o), 32'd0);
        end
        $display("abort load by reset");
        do_read(BASE);
        chk("abort_mem0", IMEM_data_o, 32'h0010_0513);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
